// File: rtl/ic_ctrl.sv
// Instruction-cache lookup/refill controller: tag lookup against a registered-read tag RAM,
// 4-beat line refill into the data RAM, and fence.i invalidate-all.
//
// state   | meaning
// S_RUN   | lookups; hit keeps one fetch per cycle, miss starts a refill
// S_MREQ  | line-fill request held until granted
// S_MDATA | four fill beats written into the data RAM
// S_TAGW  | tag written, line marked valid
// S_FLUSH | all valid bits cleared
module ic_ctrl #(
  parameter int IRWIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  output logic                  cpu_hit,
  output logic                  cpu_stall,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic [IRWIDTH-1:0]    tag_radr,
  input  logic [23-IRWIDTH:0]   tag_rdata,
  output logic [IRWIDTH-1:0]    tag_wadr,
  output logic [23-IRWIDTH:0]   tag_wdata,
  output logic                  tag_wen,
  output logic [IRWIDTH+1:0]    dram_wadr,
  output logic [31:0]           dram_wdata,
  output logic                  dram_wen,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam int TW = 24 - IRWIDTH;
  localparam int NL = 1 << IRWIDTH;

  typedef enum logic [2:0] {S_RUN, S_MREQ, S_MDATA, S_TAGW, S_FLUSH} state_t;

  state_t              state, state_nxt;
  logic [NL-1:0]       valid;
  logic                lk_vld;
  logic [IRWIDTH-1:0]  idx_q;
  logic [TW-1:0]       tag_q;
  logic [1:0]          beat;
  logic                flush_pend;

  logic [IRWIDTH-1:0]  req_idx;
  logic [TW-1:0]       req_tag;
  logic                hit, miss, go_flush, accept, fill_beat;
  logic                unused_addr;

  assign req_idx     = cpu_addr[IRWIDTH+3:4];
  assign req_tag     = cpu_addr[27:IRWIDTH+4];
  assign tag_radr    = req_idx;
  assign unused_addr = ^{cpu_addr[31:28], cpu_addr[3:0]};

  always_comb begin
    state_nxt  = state;
    hit        = 1'b0;
    miss       = 1'b0;
    go_flush   = 1'b0;
    cpu_hit    = 1'b0;
    cpu_stall  = 1'b1;
    tag_wen    = 1'b0;
    tag_wadr   = '0;
    tag_wdata  = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    fill_beat  = 1'b0;
    dram_wen   = 1'b0;
    dram_wadr  = '0;
    dram_wdata = '0;
    case (state)
      S_RUN: begin
        hit       = lk_vld & valid[idx_q] & (tag_rdata == tag_q);
        miss      = lk_vld & ~hit;
        // a miss wins over a flush; the flush is then left pending
        go_flush  = ~miss & (flush | flush_pend);
        cpu_hit   = hit;
        cpu_stall = miss | go_flush;
        if (miss)          state_nxt = S_MREQ;
        else if (go_flush) state_nxt = S_FLUSH;
      end
      S_MREQ: begin
        mem_req  = 1'b1;
        mem_addr = {4'b0, tag_q, idx_q, 4'b0};
        if (mem_gnt) state_nxt = S_MDATA;
      end
      S_MDATA: begin
        fill_beat = mem_rvalid;
        if (fill_beat) begin
          dram_wen   = 1'b1;
          dram_wadr  = {idx_q, beat};
          dram_wdata = mem_rdata;
          if (beat == 2'd3) state_nxt = S_TAGW;
        end
      end
      S_TAGW: begin
        tag_wen   = 1'b1;
        tag_wadr  = idx_q;
        tag_wdata = tag_q;
        state_nxt = (flush_pend | flush) ? S_FLUSH : S_RUN;
      end
      S_FLUSH: state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
    accept     = cpu_req & ~cpu_stall;
    flush_busy = flush_pend | flush | (state == S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      valid      <= '0;
      lk_vld     <= 1'b0;
      idx_q      <= '0;
      tag_q      <= '0;
      beat       <= 2'd0;
      flush_pend <= 1'b0;
    end else begin
      state  <= state_nxt;
      lk_vld <= accept;
      if (accept) begin
        idx_q <= req_idx;
        tag_q <= req_tag;
      end
      if (state == S_MREQ && mem_gnt)      beat <= 2'd0;
      else if (fill_beat && beat != 2'd3)  beat <= beat + 2'd1;
      // line goes invalid as soon as it starts being overwritten
      if (fill_beat && beat == 2'd0) valid[idx_q] <= 1'b0;
      if (state == S_TAGW)           valid[idx_q] <= 1'b1;
      if (state == S_FLUSH)          valid        <= '0;
      if (state == S_FLUSH)             flush_pend <= 1'b0;
      else if (flush && !go_flush)      flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ic_ctrl.sv
// Directed bench for ic_ctrl: a behavioural tag RAM plus scripted memory responses,
// with hand-computed expected values for every lookup and refill.
module tb_ic_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_hit, cpu_stall;
  logic        flush, flush_busy;
  logic [11:0] tag_radr, tag_wadr;
  logic [11:0] tag_rdata, tag_wdata;
  logic        tag_wen;
  logic [13:0] dram_wadr;
  logic [31:0] dram_wdata;
  logic        dram_wen;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] tram [0:4095];

  ic_ctrl #(.IRWIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_hit(cpu_hit), .cpu_stall(cpu_stall),
    .flush(flush), .flush_busy(flush_busy),
    .tag_radr(tag_radr), .tag_rdata(tag_rdata),
    .tag_wadr(tag_wadr), .tag_wdata(tag_wdata), .tag_wen(tag_wen),
    .dram_wadr(dram_wadr), .dram_wdata(dram_wdata), .dram_wen(dram_wen),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // 1r1w tag RAM with registered read address
  always @(posedge clk) begin
    if (tag_wen) tram[tag_wadr] <= tag_wdata;
    tag_rdata <= tram[tag_radr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'h0FFF_FFF0;
  endfunction

  function automatic logic [31:0] idx_of(input logic [31:0] a);
    return (a >> 4) & 32'hFFF;
  endfunction

  task automatic lookup(input logic [31:0] a, input logic exp_hit);
    cyc(); cpu_req = 1'b1; cpu_addr = a; #2;
    check("req_stall", {31'b0, cpu_stall}, 32'd0);
    cyc(); cpu_req = 1'b0; #2;
    check("lk_hit", {31'b0, cpu_hit}, {31'b0, exp_hit});
    check("lk_stall", {31'b0, cpu_stall}, {31'b0, ~exp_hit});
  endtask

  task automatic refill(input logic [31:0] a, input int gnt_dly, input int flush_beat);
    for (int d = 0; d < gnt_dly; d++) begin
      cyc(); mem_gnt = 1'b0; #2;
      check("wait_req", {31'b0, mem_req}, 32'd1);
      check("wait_addr", mem_addr, line_of(a));
      check("wait_nowen", {31'b0, dram_wen}, 32'd0);
      check("wait_nohit", {31'b0, cpu_hit}, 32'd0);
    end
    cyc(); mem_gnt = 1'b1; #2;
    check("mreq", {31'b0, mem_req}, 32'd1);
    check("maddr", mem_addr, line_of(a));
    check("mreq_stall", {31'b0, cpu_stall}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b0; flush = 1'b0; #2;
        check("gap_nowen", {31'b0, dram_wen}, 32'd0);
      end
      cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 | a | b;
      flush = (b == flush_beat); #2;
      check("beat_wen", {31'b0, dram_wen}, 32'd1);
      check("beat_wadr", {18'b0, dram_wadr}, (idx_of(a) << 2) | b);
      check("beat_wdata", dram_wdata, 32'hA000_0000 | a | b);
      if (flush_beat >= 0 && b >= flush_beat)
        check("beat_fbusy", {31'b0, flush_busy}, 32'd1);
    end
    cyc(); mem_rvalid = 1'b0; flush = 1'b0; #2;
    check("tagw_wen", {31'b0, tag_wen}, 32'd1);
    check("tagw_adr", {20'b0, tag_wadr}, idx_of(a));
    check("tagw_data", {20'b0, tag_wdata}, (a >> 16) & 32'hFFF);
    check("tagw_stall", {31'b0, cpu_stall}, 32'd1);
    check("tagw_nodwen", {31'b0, dram_wen}, 32'd0);
    if (flush_beat >= 0) begin
      cyc(); #2;
      check("flush_busy", {31'b0, flush_busy}, 32'd1);
      check("flush_stall", {31'b0, cpu_stall}, 32'd1);
      check("flush_notagw", {31'b0, tag_wen}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) tram[i] = 12'h0;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = 32'h0000_ABC0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    cyc(); cyc(); #2;
    check("rst_hit", {31'b0, cpu_hit}, 32'd0);
    check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    check("rst_mreq", {31'b0, mem_req}, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_tagwen", {31'b0, tag_wen}, 32'd0);
    check("rst_dwen", {31'b0, dram_wen}, 32'd0);
    check("rst_fbusy", {31'b0, flush_busy}, 32'd0);
    check("rst_radr", {20'b0, tag_radr}, 32'hABC);
    cyc(); rst = 1'b0;

    // first fill of line 0x1000
    lookup(32'h0000_1004, 1'b0);
    refill(32'h0000_1004, 0, -1);
    lookup(32'h0000_1004, 1'b1);

    // back-to-back hits
    cyc(); cpu_req = 1'b1; cpu_addr = 32'h0000_1000; #2;
    check("b2b_stall0", {31'b0, cpu_stall}, 32'd0);
    cyc(); cpu_addr = 32'h0000_1004; #2;
    check("b2b_hit1", {31'b0, cpu_hit}, 32'd1);
    check("b2b_stall1", {31'b0, cpu_stall}, 32'd0);
    cyc(); cpu_addr = 32'h0000_1008; #2;
    check("b2b_hit2", {31'b0, cpu_hit}, 32'd1);
    check("b2b_stall2", {31'b0, cpu_stall}, 32'd0);
    cyc(); cpu_req = 1'b0; #2;
    check("b2b_hit3", {31'b0, cpu_hit}, 32'd1);
    check("b2b_stall3", {31'b0, cpu_stall}, 32'd0);
    cyc(); #2;
    check("b2b_idle", {31'b0, cpu_hit}, 32'd0);

    // conflict on index 0x100
    lookup(32'h0001_1000, 1'b0);
    refill(32'h0001_1000, 0, -1);
    lookup(32'h0001_1000, 1'b1);
    lookup(32'h0000_1000, 1'b0);
    refill(32'h0000_1000, 0, -1);
    lookup(32'h0000_1000, 1'b1);

    // fence.i during a refill
    lookup(32'h0000_5040, 1'b0);
    refill(32'h0000_5040, 0, 1);
    cyc(); #2;
    check("post_flush_busy", {31'b0, flush_busy}, 32'd0);
    check("post_flush_stall", {31'b0, cpu_stall}, 32'd0);
    lookup(32'h0000_5040, 1'b0);
    refill(32'h0000_5040, 0, -1);
    lookup(32'h0000_5040, 1'b1);
    lookup(32'h0000_1000, 1'b0);
    refill(32'h0000_1000, 0, -1);

    // reset in the middle of a refill
    lookup(32'h0000_2000, 1'b0);
    cyc(); mem_gnt = 1'b1;
    cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_0000; #2;
    check("rbeat0_wen", {31'b0, dram_wen}, 32'd1);
    cyc(); mem_rdata = 32'h1111_0001; #2;
    check("rbeat1_wadr", {18'b0, dram_wadr}, 32'h801);
    cyc(); rst = 1'b1; mem_rdata = 32'h1111_0002;
    cyc(); rst = 1'b0; mem_rdata = 32'h1111_0003; #2;
    check("mid_rst_dwen", {31'b0, dram_wen}, 32'd0);
    check("mid_rst_stall", {31'b0, cpu_stall}, 32'd0);
    check("mid_rst_mreq", {31'b0, mem_req}, 32'd0);
    check("mid_rst_tagwen", {31'b0, tag_wen}, 32'd0);
    check("mid_rst_wdata", dram_wdata, 32'd0);
    cyc(); #2;
    check("stray_dwen", {31'b0, dram_wen}, 32'd0);
    mem_rvalid = 1'b0;
    lookup(32'h0000_2000, 1'b0);
    refill(32'h0000_2000, 0, -1);
    lookup(32'h0000_2000, 1'b1);

    // delayed grant
    lookup(32'h0000_3010, 1'b0);
    refill(32'h0000_3010, 5, -1);
    lookup(32'h0000_3010, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ic_ctrl.md
Name: ic_ctrl

Overview:
Instruction-cache lookup/refill controller for the IF stage.
- Drives the 1r1w tag RAM (registered read address, data valid the cycle after the address is presented) and the instruction data RAM write port.
- Holds per-line valid bits in flops.
- On a miss it fetches a 4-word line from external memory, writes the data RAM and the tag, then releases the CPU to re-issue the fetch.
- Handles fence.i invalidate-all.

Parameters:
IRWIDTH, 12, index width; tag RAM depth 2^IRWIDTH; tag width 24-IRWIDTH.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  fetch request; accepted only when cpu_stall=0
cpu_addr  in  32  fetch byte address; tag=[27:IRWIDTH+4], index=[IRWIDTH+3:4], word=[3:2]
cpu_hit  out  1  lookup of the request accepted in the previous cycle hit
cpu_stall  out  1  controller busy; current cpu_req is not accepted
flush  in  1  fence.i invalidate-all request (pulse)
flush_busy  out  1  invalidate in progress or pending
tag_radr  out  IRWIDTH  tag RAM read address
tag_rdata  in  24-IRWIDTH  tag RAM read data
tag_wadr  out  IRWIDTH  tag RAM write address
tag_wdata  out  24-IRWIDTH  tag RAM write data
tag_wen  out  1  tag RAM write enable
dram_wadr  out  IRWIDTH+2  data RAM word write address {index, beat}
dram_wdata  out  32  data RAM write data (= mem_rdata)
dram_wen  out  1  data RAM write enable
mem_req  out  1  line-fill request; held until mem_gnt
mem_addr  out  32  line-aligned fill address {4'b0, tag, index, 4'b0}
mem_gnt  in  1  memory accepts the request
mem_rvalid  in  1  fill data beat valid
mem_rdata  in  32  fill data beat

Behaviour:
Reset (rst=1 at a clock edge) produces:
- state=RUN; all valid bits=0; lk_vld=0; beat counter=0; flush_pend=0.
- All outputs 0. tag_radr follows cpu_addr index combinationally.

Reset mid-operation:
- Abandons any refill or flush immediately.
- A partially written line stays invalid.
- Stray mem_rvalid beats received in RUN are ignored.

State RUN:
- tag_radr = cpu_addr index.
- Accepting cpu_req latches tag/index and sets lk_vld=1 for the next cycle.
- Lookup cycle (lk_vld=1): hit = valid[idx_q] & (tag_rdata == tag_q).
  - Hit: cpu_hit=1 and cpu_stall=0, so back-to-back fetches run one per cycle.
  - Miss: cpu_hit=0 and cpu_stall=1 (combinational, same cycle); the new cpu_req is dropped; next state MREQ.
- flush in RUN with no miss in the current cycle: next state FLUSH.
- flush coincident with a miss: the miss takes priority; flush_pend is set.

State MREQ:
- mem_req=1, mem_addr = line address of the missed request.
- cpu_stall=1.
- On mem_gnt: next state MDATA, beat counter=0.

State MDATA:
- cpu_stall=1.
- Each mem_rvalid: dram_wen=1, dram_wadr={idx_q, beat}, beat+1.
- valid[idx_q] is cleared on the first beat.
- After beat 3: next state TAGW.

State TAGW (1 cycle):
- tag_wen=1, tag_wadr=idx_q, tag_wdata=tag_q; valid[idx_q] set.
- cpu_stall=1; lk_vld cleared.
- Next state: FLUSH if flush_pend, else RUN.
- The CPU re-issues the fetch after cpu_stall drops; it then hits.

State FLUSH (1 cycle):
- All valid bits cleared; flush_pend cleared; flush_busy=1; cpu_stall=1.
- Next state RUN.

Other rules:
- flush arriving in MREQ/MDATA/TAGW sets flush_pend; flush_busy=1 while pending.
- mem_rvalid outside MDATA is ignored.
- mem_gnt outside MREQ is ignored.
- cpu_hit is never 1 outside a RUN lookup cycle.
- Beat counter is 2 bits and does not wrap past beat 3.

Test Plan:
- Reset, then req 0x0000_1004 -> next cycle miss with cpu_stall=1. Then mem_req=1 with mem_addr=0x0000_1000; gnt; 4 beats write dram_wadr 0x400..0x403; tag_wen with tag_wadr=0x100, tag_wdata=0x000. Re-issue 0x0000_1004 -> cpu_hit=1 one cycle later.
- After filling line 0x1000: reqs 0x1000, 0x1004, 0x1008 on consecutive cycles -> cpu_hit=1 on three consecutive cycles, cpu_stall=0 throughout.
- Conflict: 0x0001_1000 (index 0x100, tag 0x001) -> miss and refill overwrite tag to 0x001. Re-issue 0x0000_1000 -> miss.
- flush pulse during MDATA beat 1 -> flush_busy=1 immediately. Refill completes, then one FLUSH cycle. Re-issue the filled address -> miss.
- rst asserted after 2 beats -> all outputs 0 next cycle; remaining mem_rvalid beats cause no dram_wen. Re-issue -> miss, full refill.
- mem_gnt delayed 5 cycles -> mem_req and mem_addr held stable for all 5 cycles; no dram_wen before the grant.
